// File: rtl/plic_claim_master.sv
// plic_claim_master: per-hart Wishbone initiator that claims, presents and completes PLIC interrupts.
module plic_claim_master #(
    parameter int              AW            = 32,
    parameter int              DW            = 32,
    parameter int              ID_W          = 2,
    parameter logic [AW-1:0]   CLAIM_ADDR    = 32'h0C20_0004,
    parameter logic [AW-1:0]   COMPLETE_ADDR = 32'h0C20_0008,
    parameter int              TIMEOUT       = 64,
    parameter int              REARM_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq_i,
    input  logic            irq_en_i,
    output logic            irq_valid_o,
    output logic [ID_W-1:0] irq_id_o,
    input  logic            irq_done_i,
    output logic            err_o,
    input  logic            err_clr_i,
    output logic [7:0]      spurious_cnt_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_addr_o,
    output logic [DW-1:0]   wbm_wdata_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_rdata_i,
    input  logic            wbm_ack_i
);
    typedef enum logic [2:0] {S_IDLE, S_CLAIM, S_SERVICE, S_COMPLETE, S_REARM} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_tmo;
    logic [3:0]      r_rearm;
    logic            r_err;
    logic [7:0]      r_spur;
    logic            w_busy;
    logic            w_expire;
    logic            w_tmo_hit;
    logic            w_spur_inc;
    logic            w_start;
    logic [ID_W-1:0] w_rd_id;
    logic            w_unused_rdata;

    assign w_rd_id        = wbm_rdata_i[ID_W-1:0];
    assign w_unused_rdata = ^wbm_rdata_i[DW-1:ID_W];

    always_comb begin
        w_next     = r_state;
        w_tmo_hit  = 1'b0;
        w_spur_inc = 1'b0;
        w_start    = ext_irq_i && irq_en_i;
        w_busy     = (r_state == S_CLAIM) || (r_state == S_COMPLETE);
        w_expire   = r_tmo == 8'(TIMEOUT - 1);
        case (r_state)
            S_IDLE:     w_next = w_start ? S_CLAIM : S_IDLE;
            S_CLAIM: begin
                if (wbm_ack_i) begin
                    w_next     = (w_rd_id != '0) ? S_SERVICE : S_REARM;
                    w_spur_inc = w_rd_id == '0;
                end else if (w_expire) begin
                    w_next    = S_REARM;
                    w_tmo_hit = 1'b1;
                end
            end
            S_SERVICE:  w_next = irq_done_i ? S_COMPLETE : S_SERVICE;
            S_COMPLETE: begin
                w_next    = (wbm_ack_i || w_expire) ? S_REARM : S_COMPLETE;
                w_tmo_hit = !wbm_ack_i && w_expire;
            end
            // The final rearm cycle doubles as the idle decision so the gap is exactly REARM_CYCLES.
            S_REARM:    w_next = (r_rearm == 4'(REARM_CYCLES - 1)) ? (w_start ? S_CLAIM : S_IDLE) : S_REARM;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_tmo   <= '0;
            r_rearm <= '0;
            r_err   <= 1'b0;
            r_spur  <= '0;
        end else begin
            r_state <= w_next;
            r_tmo   <= (w_busy && w_next == r_state) ? r_tmo + 8'd1 : 8'd0;
            r_rearm <= (r_state == S_REARM && w_next == S_REARM) ? r_rearm + 4'd1 : 4'd0;
            if (r_state == S_CLAIM && wbm_ack_i)
                r_id <= w_rd_id;
            else if ((r_state == S_COMPLETE && wbm_ack_i) || w_tmo_hit)
                r_id <= '0;
            r_err   <= w_tmo_hit || (r_err && !err_clr_i);
            if (w_spur_inc && r_spur != 8'hFF)
                r_spur <= r_spur + 8'd1;
        end
    end

    assign irq_valid_o    = r_state == S_SERVICE;
    assign irq_id_o       = r_id;
    assign err_o          = r_err;
    assign spurious_cnt_o = r_spur;
    assign wbm_cyc_o      = w_busy;
    assign wbm_stb_o      = w_busy;
    assign wbm_we_o       = r_state == S_COMPLETE;
    assign wbm_addr_o     = (r_state == S_CLAIM) ? CLAIM_ADDR : (r_state == S_COMPLETE) ? COMPLETE_ADDR : '0;
    assign wbm_wdata_o    = (r_state == S_COMPLETE) ? {{(DW-ID_W){1'b0}}, r_id} : '0;
    assign wbm_sel_o      = {(DW/8){w_busy}};
endmodule
